mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- Bus initiator for the single-port `memory` block.
- Turns single-word read/write requests from the CPU/load-store side into the memory's strobe sequence: `address`, `write_enable`, `output_enable`, and a shared tri-state `data_bus`.
- Sequences the memory's one-cycle registered read latency.
- Guarantees the controller and the memory never drive `data_bus` in the same cycle.

Parameters:
- ADDR_WIDTH, 11, word address width; matches the memory.
- DATA_WIDTH, 16, word width; matches the memory.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; accepted only when ready=1.
- req_we  in  1  1 = write, 0 = read; sampled on accept.
- req_addr  in  ADDR_WIDTH  word address; sampled on accept.
- req_wdata  in  DATA_WIDTH  write data; sampled on accept.
- ready  out  1  controller idle, can accept a request.
- done  out  1  one-cycle pulse when the transaction completes.
- rdata  out  DATA_WIDTH  read result; valid while done=1 for a read; held until the next read completes.
- verify_err  out  1  write-verify mismatch; valid with done.
- mem_address  out  ADDR_WIDTH  drives memory `address`.
- mem_write_enable  out  1  drives memory `write_enable`.
- mem_output_enable  out  1  drives memory `output_enable`.
- mem_data_bus  inout  DATA_WIDTH  shared bus to memory `data_bus`.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, ready=1, done=0, rdata=0, verify_err=0.
  - mem_write_enable=0, mem_output_enable=0, mem_address=0.
  - mem_data_bus released to 'z.
- States: IDLE, WRITE, RD_ADDR, RD_DATA. All strobes are registered outputs of the state register; no combinational path from req to the memory pins.
- IDLE:
  - ready=1; strobes low.
  - On req=1 at a rising edge, latch addr/wdata/we into holding registers.
  - Next state: WRITE if we=1, else RD_ADDR.
  - req while ready=0 is ignored; there is no queueing.
- WRITE (1 cycle):
  - mem_address=addr_q, mem_write_enable=1, mem_output_enable=0.
  - Controller drives mem_data_bus=wdata_q.
  - The memory samples at the closing edge.
  - Next state: IDLE, with done=1 for one cycle.
- RD_ADDR (1 cycle):
  - mem_address=addr_q, mem_write_enable=0, mem_output_enable=1.
  - Bus released; the memory registers its read data at the closing edge.
- RD_DATA (1 cycle):
  - Strobes held as in RD_ADDR; the memory drives the bus.
  - rdata <= mem_data_bus at the closing edge.
  - Next state: IDLE, with done=1.
- Latency, counting the accept edge as edge 0:
  - Write: done high in the cycle after edge 2.
  - Read: done high in the cycle after edge 3, with rdata valid.
- Back-to-back: ready=1 in the same cycle done=1, so a new req is accepted immediately. Throughput is 1 write per 2 cycles and 1 read per 3 cycles.
- Bus ownership:
  - Controller drives mem_data_bus only when mem_write_enable=1; otherwise 'z.
  - mem_write_enable and mem_output_enable are never both 1.
- Reset mid-transaction: the transaction is abandoned and done is not issued. A write aborted in WRITE may or may not have reached the memory, so the requester must reissue it.
- The memory's own synchronous reset is not driven by this block.

Optional Feature:
- Macro: MEM_BUS_MASTER_WRITE_VERIFY_EN.
- With the macro:
  - WRITE is followed by RD_ADDR and RD_DATA.
  - The read-back value is compared to wdata_q.
  - verify_err=1 with done on mismatch, otherwise 0.
  - Write done arrives after edge 4.
  - rdata is unchanged by verify reads.
- Without the macro: verify_err is tied to 0 and write latency is as above.

Test Plan:
- Reset: assert reset asynchronously mid-clock -> ready=1, done=0, rdata=0, both enables 0, mem_data_bus='z before the next edge.
- Write then read: write 0xBEEF to addr 0x005, then read 0x005 -> write done after edge 2; read done after edge 3 with rdata=0xBEEF; we/oe never both high.
- Back-to-back: write 0x1234 to 0x7FF, with req held so a read of 0x7FF is accepted on the done cycle -> rdata=0x1234; no idle cycles between transactions.
- Ignored request: pulse req during RD_ADDR -> no extra transaction; exactly one done pulse.
- Reset mid-write: assert reset in WRITE -> immediate return to IDLE, no done, bus 'z; a subsequent read of the same address completes normally.
- Verify (macro on): the memory model corrupts bit 0 on read-back of a 0x00FF write -> done with verify_err=1; a clean write gives verify_err=0; write latency is 4 edges.

Source files
------------

// File: rtl/mem_bus_master.sv
// mem_bus_master
//   Bus initiator for the single-port `memory` block. Turns single-word
//   read/write requests into the memory strobe sequence and owns its side
//   of the shared tri-state data bus.
//
//   Optional feature macro: MEM_BUS_MASTER_WRITE_VERIFY_EN
//     When defined, every write is followed by a read-back of the same word.
//     verify_err reports a mismatch alongside done.
//     When undefined, verify_err is tied low.
//
//   Ports
//     clk, reset          rising-edge clock, asynchronous active-high reset
//     req, req_we         request strobe (taken only while ready=1), 1=write
//     req_addr, req_wdata word address / write data, sampled on accept
//     ready               idle, a request will be accepted
//     done                one-cycle completion pulse
//     rdata               last read result, held until the next read completes
//     verify_err          write-verify mismatch, valid with done
//     mem_address         memory address pins
//     mem_write_enable    memory write strobe
//     mem_output_enable   memory output-enable strobe
//     mem_data_bus        shared tri-state data bus

module mem_bus_master #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  verify_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic                  mem_output_enable,
  inout  wire  [DATA_WIDTH-1:0] mem_data_bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
  // Distinguishes a verify read-back from a plain read in RD_ADDR/RD_DATA.
  logic                  is_wr_q, is_wr_d;
  logic                  verr_q, verr_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
    is_wr_d = is_wr_q;
    verr_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
          is_wr_d = req_we;
`endif
          state_d = req_we ? WRITE : RD_ADDR;
        end
      end

      WRITE: begin
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
        // Read the word straight back before reporting completion.
        state_d = RD_ADDR;
`else
        state_d = IDLE;
        done_d  = 1'b1;
`endif
      end

      RD_ADDR: begin
        // Memory registers its read data at the end of this cycle.
        state_d = RD_DATA;
      end

      RD_DATA: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
        if (is_wr_q) begin
          // Verify read-backs leave rdata untouched.
          verr_d = (mem_data_bus != wdata_q);
        end else begin
          rdata_d = mem_data_bus;
        end
`else
        rdata_d = mem_data_bus;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin values are decoded from the *next* state so every strobe comes
    // straight out of a flop in the same cycle as the state it belongs to.
    ready_d    = (state_d == IDLE);
    mem_we_d   = (state_d == WRITE);
    mem_oe_d   = (state_d == RD_ADDR) || (state_d == RD_DATA);
    mem_addr_d = (state_d == IDLE) ? mem_addr_q : addr_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_oe_q   <= 1'b0;
      mem_addr_q <= '0;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
      is_wr_q    <= 1'b0;
      verr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      mem_we_q   <= mem_we_d;
      mem_oe_q   <= mem_oe_d;
      mem_addr_q <= mem_addr_d;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
      is_wr_q    <= is_wr_d;
      verr_q     <= verr_d;
`endif
    end
  end

  assign ready             = ready_q;
  assign done              = done_q;
  assign rdata             = rdata_q;
  assign mem_address       = mem_addr_q;
  assign mem_write_enable  = mem_we_q;
  assign mem_output_enable = mem_oe_q;

`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
  assign verify_err = verr_q;
`else
  assign verify_err = 1'b0;
`endif

  // Drive the bus only while writing. The write and output-enable strobes
  // decode mutually exclusive states, so the memory is never driving then.
  assign mem_data_bus = mem_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master
//   Self-checking bench for mem_bus_master. It contains a simple memory
//   device on the shared bus, a transaction-level reference model
//   (acceptance, latency, expected data), one per-cycle compare process, and
//   directed tests with literal expectations.
//   The bus carries a pull-up, so a fully released bus reads as all ones.

module tb_mem_bus_master;

  localparam int AW = 11;
  localparam int DW = 16;
`ifdef MEM_BUS_MASTER_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int L_WR = VERIFY ? 4 : 2;
  localparam int L_RD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          ready, done, verify_err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_address;
  logic          mem_write_enable, mem_output_enable;
  wire  [DW-1:0] mem_data_bus;

  always #5 clk = ~clk;

  mem_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .reset             (rst),
    .req               (req),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .ready             (ready),
    .done              (done),
    .rdata             (rdata),
    .verify_err        (verify_err),
    .mem_address       (mem_address),
    .mem_write_enable  (mem_write_enable),
    .mem_output_enable (mem_output_enable),
    .mem_data_bus      (mem_data_bus)
  );

  // ---------------- memory device ----------------
  logic [DW-1:0] dev_mem [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] dev_rd = '0;
  bit            corrupt_en = 1'b0;

  always @(posedge clk) begin
    if (mem_write_enable) dev_mem[mem_address] <= mem_data_bus;
    if (mem_output_enable)
      dev_rd <= (corrupt_en && dev_mem[mem_address] == 16'h00FF) ? 16'h00FE
                                                                 : dev_mem[mem_address];
  end
  assign mem_data_bus = mem_output_enable ? dev_rd : {DW{1'bz}};
  pullup (mem_data_bus);

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks one transaction: accepted at edge m_acc, done seen in the cycle
  // that closes at edge m_acc + m_lat, strobes active at offsets in between.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
  int            m_edge = 0;
  int            m_acc = 0;
  int            m_lat = 0;
  bit            m_busy = 1'b0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_old = '0;
  logic [DW-1:0] m_exp_rd = '0;
  logic [DW-1:0] m_exp_alt = '0;
  bit            m_exp_verr = 1'b0;
  logic [DW-1:0] m_last_rd = '0;
  bit            m_last_amb = 1'b0;
  // A write aborted by reset may or may not have landed.
  bit            amb_valid = 1'b0;
  logic [AW-1:0] amb_addr = '0;
  logic [DW-1:0] amb_old = '0;

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        if (m_busy && m_we && (m_edge < m_acc + 1)) begin
          amb_valid = 1'b1;
          amb_addr  = m_addr;
          amb_old   = m_old;
        end
        m_busy     = 1'b0;
        m_last_rd  = '0;
        m_last_amb = 1'b0;
      end else begin
        m_edge = m_edge + 1;
        if (req && (!m_busy || m_edge >= m_acc + m_lat)) begin
          m_busy  = 1'b1;
          m_acc   = m_edge;
          m_we    = req_we;
          m_addr  = req_addr;
          m_wdata = req_wdata;
          if (req_we) begin
            m_lat = L_WR;
            m_old = ref_mem[req_addr];
            ref_mem[req_addr] = req_wdata;
            m_exp_verr = VERIFY && corrupt_en && (req_wdata == 16'h00FF);
            if (amb_valid && amb_addr == req_addr) amb_valid = 1'b0;
          end else begin
            m_lat      = L_RD;
            m_exp_rd   = ref_mem[req_addr];
            m_exp_alt  = (amb_valid && amb_addr == req_addr) ? amb_old : m_exp_rd;
            m_last_rd  = m_exp_rd;
            m_last_amb = (m_exp_alt != m_exp_rd);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  initial begin : compare
    int e, k;
    bit x_active, x_done, x_we, x_oe;
    forever begin
      @(negedge clk);
      if (cmp_en && !rst) begin
        e        = m_edge + 1;
        k        = e - m_acc;
        x_active = m_busy && (e < m_acc + m_lat);
        x_done   = m_busy && (e == m_acc + m_lat);
        x_we     = m_busy && m_we && (k == 1);
        x_oe     = m_busy && ((!m_we && (k == 1 || k == 2)) ||
                              (VERIFY && m_we && (k == 2 || k == 3)));
        check("ready", ready, !x_active);
        check("done", done, x_done);
        check("we", mem_write_enable, x_we);
        check("oe", mem_output_enable, x_oe);
        check("we_oe_excl", mem_write_enable && mem_output_enable, 0);
        if (x_we || x_oe) check("addr", mem_address, m_addr);
        if (x_we) check("bus_wr", mem_data_bus, m_wdata);
        if (!x_we && !x_oe) check("bus_rel", mem_data_bus, 16'hFFFF);
        if (x_done && !m_we) begin
          if (m_exp_alt != m_exp_rd && rdata == m_exp_alt)
            check("rdata", rdata, m_exp_alt);
          else
            check("rdata", rdata, m_exp_rd);
          check("verr_rd", verify_err, 0);
        end
        if (x_done && m_we) begin
          check("verr_wr", verify_err, m_exp_verr);
          if (!m_last_amb) check("rdata_hold", rdata, m_last_rd);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Issue one request from a point away from the clock edge, then count
  // cycles until done (bounded). lat = 0 means done never arrived.
  task automatic do_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic [DW-1:0] rd, output bit verr);
    req = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk);
    #2 req = 1'b0;
    lat = 0; rd = '0; verr = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n; rd = rdata; verr = verify_err;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_verr"}, verify_err, 0);
    check({tag, "_we"}, mem_write_enable, 0);
    check({tag, "_oe"}, mem_output_enable, 0);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_bus"}, mem_data_bus, 16'hFFFF);
  endtask

  logic [AW-1:0] t_addr [4] = '{11'h000, 11'h400, 11'h2AA, 11'h555};
  logic [DW-1:0] t_data [4] = '{16'h0001, 16'h8000, 16'hAAAA, 16'h5555};

  initial begin : stim
    int lat, n1, n2, pulses;
    logic [DW-1:0] rd;
    bit verr;

    // Power-up reset, asserted between clock edges.
    #3 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Write then read.
    do_txn(1'b1, 11'h005, 16'hBEEF, lat, rd, verr);
    check("wr_beef_lat", lat, L_WR);
    do_txn(1'b0, 11'h005, 16'h0000, lat, rd, verr);
    check("rd_beef_lat", lat, 3);
    check("rd_beef_data", rd, 16'hBEEF);

    // Asynchronous reset mid-clock while idle clears the held rdata.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Back-to-back: req held so the read is taken on the write's done cycle.
    req = 1'b1; req_we = 1'b1; req_addr = 11'h7FF; req_wdata = 16'h1234;
    @(posedge clk);
    #2 req_we = 1'b0;
    n1 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin n1 = n; break; end
    end
    @(posedge clk);
    #2 req = 1'b0;
    n2 = 0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin n2 = n; rd = rdata; break; end
    end
    check("b2b_wr_lat", n1, L_WR);
    check("b2b_rd_lat", n2, 3);
    check("b2b_rd_data", rd, 16'h1234);

    // Request during RD_ADDR is ignored.
    req = 1'b1; req_we = 1'b0; req_addr = 11'h005;
    @(posedge clk);
    #2 req = 1'b0;
    @(negedge clk);
    check("ign_ready", ready, 0);
    req = 1'b1; req_we = 1'b1; req_addr = 11'h00A; req_wdata = 16'hDEAD;
    @(posedge clk);
    #2 req = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) begin pulses++; rd = rdata; end
    end
    check("ign_pulses", pulses, 1);
    check("ign_rd_data", rd, 16'hBEEF);
    do_txn(1'b0, 11'h00A, 16'h0000, lat, rd, verr);
    check("ign_not_written", rd, 16'h0000);

    // Reset during WRITE: abandoned, no done, bus released at once.
    do_txn(1'b1, 11'h0A0, 16'h1111, lat, rd, verr);
    check("pre_abort_lat", lat, L_WR);
    req = 1'b1; req_we = 1'b1; req_addr = 11'h0A0; req_wdata = 16'h2222;
    @(posedge clk);
    #2 req = 1'b0;
    @(negedge clk);
    check("abort_in_write", mem_write_enable, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_we", mem_write_enable, 0);
    check("abort_oe", mem_output_enable, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check("abort_bus", mem_data_bus, 16'hFFFF);
    @(posedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    do_txn(1'b0, 11'h0A0, 16'h0000, lat, rd, verr);
    check("abort_rd_lat", lat, 3);
    check("abort_rd_data", (rd == 16'h1111 || rd == 16'h2222), 1);

    // Write-verify: clean write, read back, then a corrupted read-back.
    do_txn(1'b1, 11'h034, 16'h0F0F, lat, rd, verr);
    check("vfy_clean_lat", lat, L_WR);
    check("vfy_clean_err", verr, 0);
    do_txn(1'b0, 11'h034, 16'h0000, lat, rd, verr);
    check("vfy_rd_data", rd, 16'h0F0F);
    corrupt_en = 1'b1;
    do_txn(1'b1, 11'h033, 16'h00FF, lat, rd, verr);
    check("vfy_bad_lat", lat, L_WR);
    check("vfy_bad_err", verr, VERIFY ? 1 : 0);
    check("vfy_rdata_kept", rd, 16'h0F0F);
    corrupt_en = 1'b0;

    // A small table of writes followed by reads.
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b1, t_addr[i], t_data[i], lat, rd, verr);
      check("tbl_wr_lat", lat, L_WR);
    end
    for (int i = 3; i >= 0; i--) begin
      do_txn(1'b0, t_addr[i], 16'h0000, lat, rd, verr);
      check("tbl_rd_data", rd, t_data[i]);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
